// File: rtl/ypbpr_pkg.sv
// rtl/ypbpr_pkg.sv - shared constants and helpers for the YPbPr to RGB converter
//
// Holds the x256 fixed-point colour coefficients, the chroma offset, the
// rounding term, the fixed pipeline depth and the intermediate sum width.
// clamp8() turns a x256 fixed-point sum into a saturated 8-bit component.

package ypbpr_pkg;

    localparam int KR         = 359;  // 1.402 * 256
    localparam int KGB        = 88;   // 0.344 * 256
    localparam int KGR        = 183;  // 0.714 * 256
    localparam int KB         = 454;  // 1.772 * 256
    localparam int CHROMA_OFS = 128;
    localparam int ROUND      = 128;  // half an LSB after the >>8
    localparam int LATENCY    = 4;
    localparam int IW         = 19;

    // Drop the 8 fractional bits (floor) and saturate to 0..255.
    function automatic logic [7:0] clamp8(input logic signed [IW-1:0] sum);
        logic signed [IW-1:0] t;
        t = sum >>> 8;
        if (t < 0) begin
            return 8'h00;
        end else if (t > 255) begin
            return 8'hff;
        end
        return t[7:0];
    endfunction

endpackage

// File: rtl/sync_delay.sv
// rtl/sync_delay.sv - fixed-depth shift register with per-bit reset value
//
// Ports:
//   clk     - rising-edge clock
//   reset_n - synchronous active-low reset, loads every stage with RST_VAL
//   din     - WIDTH-bit input
//   dout    - din delayed by DEPTH cycles

module sync_delay #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/ypbpr_to_rgb.sv
// rtl/ypbpr_to_rgb.sv - 4-stage YPbPr to RGB converter with bypass and sync alignment
//
// Ports:
//   clk      - rising-edge clock
//   reset_n  - synchronous active-low reset
//   bypass   - pass din through unconverted (takes effect only between lines)
//   csync    - composite sync, active-low, timed with din
//   de       - data enable, timed with din
//   din      - {pr, y, pb}, 8 bits each, chroma offset 128
//   dout     - {r, g, b}, LATENCY cycles after din
//   csync_o  - csync delayed LATENCY cycles
//   de_o     - de delayed LATENCY cycles
//
// Stages: 1 offset removal, 2 products, 3 sums with rounding, 4 shift and clamp.

module ypbpr_to_rgb #(
    parameter bit BLANK_ZERO = 1'b1,
    parameter int LATENCY    = ypbpr_pkg::LATENCY
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        bypass,
    input  logic        csync,
    input  logic        de,
    input  logic [23:0] din,
    output logic [23:0] dout,
    output logic        csync_o,
    output logic        de_o
);

    import ypbpr_pkg::*;

    if (LATENCY != ypbpr_pkg::LATENCY) begin : g_bad_latency
        $error("ypbpr_to_rgb: LATENCY is fixed at 4");
    end

    logic signed [8:0]    y_q, y_d, cb_q, cb_d, cr_q, cr_d;
    logic signed [IW-1:0] ysh_q, ysh_d, kr_q, kr_d, kgb_q, kgb_d;
    logic signed [IW-1:0] kgr_q, kgr_d, kb_q, kb_d;
    logic signed [IW-1:0] r_sum_q, r_sum_d, g_sum_q, g_sum_d, b_sum_q, b_sum_d;
    logic [23:0]          rgb_q, rgb_d;
    logic [23:0]          din_pipe_q [LATENCY];
    logic [23:0]          din_pipe_d [LATENCY];
    logic                 mode_act_q, mode_act_d;
    logic [2:0]           dly_out;
    logic                 mode_o;

    always_comb begin
        // Stage 1: Y zero-extended, chroma re-centred around zero.
        y_d  = $signed({1'b0, din[15:8]});
        cb_d = 9'($signed({1'b0, din[7:0]}) - CHROMA_OFS);
        cr_d = 9'($signed({1'b0, din[23:16]}) - CHROMA_OFS);

        // Stage 2: products in x256 fixed point.
        ysh_d = IW'(y_q) <<< 8;
        kr_d  = IW'(cr_q * KR);
        kgb_d = IW'(cb_q * KGB);
        kgr_d = IW'(cr_q * KGR);
        kb_d  = IW'(cb_q * KB);

        // Stage 3: sums with rounding term.
        r_sum_d = IW'(ysh_q + kr_q + ROUND);
        g_sum_d = IW'(ysh_q - kgb_q - kgr_q + ROUND);
        b_sum_d = IW'(ysh_q + kb_q + ROUND);

        // Stage 4: shift and saturate.
        rgb_d = {clamp8(r_sum_q), clamp8(g_sum_q), clamp8(b_sum_q)};

        // Raw pixel follows the arithmetic so bypass output lines up with it.
        din_pipe_d[0] = din;
        for (int i = 1; i < LATENCY; i++) begin
            din_pipe_d[i] = din_pipe_q[i-1];
        end

        // Mode may only change while blanked so a line is never split.
        mode_act_d = de ? mode_act_q : bypass;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            y_q        <= '0;
            cb_q       <= '0;
            cr_q       <= '0;
            ysh_q      <= '0;
            kr_q       <= '0;
            kgb_q      <= '0;
            kgr_q      <= '0;
            kb_q       <= '0;
            r_sum_q    <= '0;
            g_sum_q    <= '0;
            b_sum_q    <= '0;
            rgb_q      <= '0;
            mode_act_q <= 1'b0;
            for (int i = 0; i < LATENCY; i++) begin
                din_pipe_q[i] <= '0;
            end
        end else begin
            y_q        <= y_d;
            cb_q       <= cb_d;
            cr_q       <= cr_d;
            ysh_q      <= ysh_d;
            kr_q       <= kr_d;
            kgb_q      <= kgb_d;
            kgr_q      <= kgr_d;
            kb_q       <= kb_d;
            r_sum_q    <= r_sum_d;
            g_sum_q    <= g_sum_d;
            b_sum_q    <= b_sum_d;
            rgb_q      <= rgb_d;
            mode_act_q <= mode_act_d;
            din_pipe_q <= din_pipe_d;
        end
    end

    // Reset value: csync inactive (1), de 0, convert mode.
    sync_delay #(
        .WIDTH   (3),
        .DEPTH   (LATENCY),
        .RST_VAL (3'b100)
    ) u_sync_delay (
        .clk     (clk),
        .reset_n (reset_n),
        .din     ({csync, de, mode_act_q}),
        .dout    (dly_out)
    );

    assign csync_o = dly_out[2];
    assign de_o    = dly_out[1];
    assign mode_o  = dly_out[0];

    assign dout = (BLANK_ZERO && !de_o) ? 24'h000000
                : (mode_o ? din_pipe_q[LATENCY-1] : rgb_q);

endmodule
